// File: rtl/ring_noc_pkg.sv
// Shared ring NoC definitions: polarity encoding and the default flit width.
package ring_noc_pkg;

   localparam logic POL_WR_EVEN = 1'b1;
   localparam logic POL_WR_ODD  = 1'b0;
   localparam int   FLIT_W      = 64;

endpackage

// File: rtl/router_input_vc_buffer_if.sv
// Upstream link, switch port, occupancy and error signals of the VC input buffer.
interface router_input_vc_buffer_if
   import ring_noc_pkg::*;
#(
   parameter int DATA_W = FLIT_W,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
);
   logic              polarity;
   logic              si;
   logic [DATA_W-1:0] di;
   logic              ri;
   logic              req;
   logic [DATA_W-1:0] dout;
   logic              ack;
   logic [CNT_W-1:0]  even_cnt;
   logic [CNT_W-1:0]  odd_cnt;
   logic              err_ovf;
   logic              err_unf;

   modport master (
      output polarity, si, di, ack,
      input  ri, req, dout, even_cnt, odd_cnt, err_ovf, err_unf
   );

   modport slave (
      input  polarity, si, di, ack,
      output ri, req, dout, even_cnt, odd_cnt, err_ovf, err_unf
   );
endinterface

// File: rtl/router_vc_fifo.sv
// One virtual-channel bank: DEPTH-entry FIFO, registered write, combinational head read.
// Caller must qualify push with !full and pop with !empty; storage resets to zero so dout is never X.
module router_vc_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // Explicit wrap so non-power-of-two depths stay in range.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
endmodule

// File: rtl/router_input_vc_buffer.sv
// Two-bank VC input stage: polarity steers upstream writes to one bank and switch reads from the other.
// Flit readable the cycle after its push; ri drops when the write bank is full, req when the read bank is empty.
module router_input_vc_buffer
   import ring_noc_pkg::*;
#(
   parameter int DATA_W = FLIT_W,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input logic                     clk,
   input logic                     reset,
   router_input_vc_buffer_if.slave bus
);
   logic              wr_even;
   logic              push_even, push_odd;
   logic              pop_even, pop_odd;
   logic              even_full, odd_full;
   logic              even_empty, odd_empty;
   logic [DATA_W-1:0] even_dout, odd_dout;
   logic              ri_int, req_int;
   logic              err_ovf_q, err_unf_q;

   assign wr_even = (bus.polarity == POL_WR_EVEN);
   assign ri_int  = wr_even ? !even_full : !odd_full;
   assign req_int = wr_even ? !odd_empty : !even_empty;

   // Write and read banks always differ, so one FIFO never sees push and pop together.
   assign push_even = bus.si  && ri_int  &&  wr_even;
   assign push_odd  = bus.si  && ri_int  && !wr_even;
   assign pop_even  = bus.ack && req_int && !wr_even;
   assign pop_odd   = bus.ack && req_int &&  wr_even;

   router_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_even (
      .clk   (clk),
      .reset (reset),
      .push  (push_even),
      .din   (bus.di),
      .pop   (pop_even),
      .dout  (even_dout),
      .count (bus.even_cnt),
      .full  (even_full),
      .empty (even_empty)
   );

   router_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_odd (
      .clk   (clk),
      .reset (reset),
      .push  (push_odd),
      .din   (bus.di),
      .pop   (pop_odd),
      .dout  (odd_dout),
      .count (bus.odd_cnt),
      .full  (odd_full),
      .empty (odd_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         if (bus.si && !ri_int)
            err_ovf_q <= 1'b1;
         if (bus.ack && !req_int)
            err_unf_q <= 1'b1;
      end
   end

   assign bus.ri      = ri_int;
   assign bus.req     = req_int;
   assign bus.dout    = wr_even ? odd_dout : even_dout;
   assign bus.err_ovf = err_ovf_q;
   assign bus.err_unf = err_unf_q;
endmodule

// File: tb/tb_router_input_vc_buffer.sv
// Scoreboard bench: DEPTH=4 and DEPTH=3 instances share stimulus; a queue-based bank model predicts outputs.
module tb_router_input_vc_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        pol;
   logic        si;
   logic        ack;
   logic [63:0] di;

   always #5 clk = ~clk;

   router_input_vc_buffer_if #(.DATA_W(64), .DEPTH(4)) if4 ();
   router_input_vc_buffer_if #(.DATA_W(64), .DEPTH(3)) if3 ();

   assign if4.polarity = pol;
   assign if4.si       = si;
   assign if4.di       = di;
   assign if4.ack      = ack;
   assign if3.polarity = pol;
   assign if3.si       = si;
   assign if3.di       = di;
   assign if3.ack      = ack;

   router_input_vc_buffer #(.DATA_W(64), .DEPTH(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (if4.slave)
   );

   router_input_vc_buffer #(.DATA_W(64), .DEPTH(3)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (if3.slave)
   );

   typedef logic [63:0] flit_q_t[$];
   typedef struct {
      int          dut;
      logic        ri;
      logic        req;
      logic [63:0] dout;
      logic        dchk;
      int          ec;
      int          oc;
      logic        ovf;
      logic        unf;
   } exp_t;

   // Model: bank b of instance d lives in mq[d*2+b] (b=0 even, b=1 odd).
   flit_q_t mq [4];
   bit      written [4];
   bit      ovf_m [2];
   bit      unf_m [2];
   int      dep [2] = '{4, 3};
   bit      model_ok = 1'b0;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic cmp(string name, int d, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s depth%0d @%0t: got 0x%0h expected 0x%0h", name, dep[d], $time, act, exp);
      end
   endtask

   function automatic exp_t predict(int d);
      exp_t e;
      int   wb = (pol == 1'b1) ? 0 : 1;
      int   rb = 1 - wb;
      e.dut  = d;
      e.ri   = (mq[d*2+wb].size() != dep[d]);
      e.req  = (mq[d*2+rb].size() != 0);
      e.dout = 64'h0;
      e.dchk = 1'b0;
      if (e.req) begin
         e.dout = mq[d*2+rb][0];
         e.dchk = 1'b1;
      end else if (!written[d*2+rb]) begin
         e.dchk = 1'b1;
      end
      e.ec  = mq[d*2].size();
      e.oc  = mq[d*2+1].size();
      e.ovf = ovf_m[d];
      e.unf = unf_m[d];
      return e;
   endfunction

   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         int wb = (pol == 1'b1) ? 0 : 1;
         int rb = 1 - wb;
         if (reset) begin
            for (int b = 0; b < 2; b++) begin
               mq[d*2+b].delete();
               written[d*2+b] = 1'b0;
            end
            ovf_m[d] = 1'b0;
            unf_m[d] = 1'b0;
         end else begin
            if (si) begin
               if (mq[d*2+wb].size() < dep[d]) begin
                  mq[d*2+wb].push_back(di);
                  written[d*2+wb] = 1'b1;
               end else begin
                  ovf_m[d] = 1'b1;
               end
            end
            if (ack) begin
               if (mq[d*2+rb].size() > 0)
                  void'(mq[d*2+rb].pop_front());
               else
                  unf_m[d] = 1'b1;
            end
         end
      end
      if (reset)
         model_ok = 1'b1;
   endtask

   // One cycle: drive, queue the predicted outputs, then advance the model at the edge.
   task automatic step(bit r, bit p, bit s, logic [63:0] d, bit a);
      reset = r;
      pol   = p;
      si    = s;
      di    = d;
      ack   = a;
      #1;
      if (model_ok) begin
         exp_q.push_back(predict(0));
         exp_q.push_back(predict(1));
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   always @(negedge clk) begin
      while (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.dut == 0) begin
            cmp("ri", 0, 64'(if4.ri), 64'(e.ri));
            cmp("req", 0, 64'(if4.req), 64'(e.req));
            if (e.dchk) cmp("dout", 0, if4.dout, e.dout);
            cmp("even_cnt", 0, 64'(if4.even_cnt), 64'(e.ec));
            cmp("odd_cnt", 0, 64'(if4.odd_cnt), 64'(e.oc));
            cmp("err_ovf", 0, 64'(if4.err_ovf), 64'(e.ovf));
            cmp("err_unf", 0, 64'(if4.err_unf), 64'(e.unf));
         end else begin
            cmp("ri", 1, 64'(if3.ri), 64'(e.ri));
            cmp("req", 1, 64'(if3.req), 64'(e.req));
            if (e.dchk) cmp("dout", 1, if3.dout, e.dout);
            cmp("even_cnt", 1, 64'(if3.even_cnt), 64'(e.ec));
            cmp("odd_cnt", 1, 64'(if3.odd_cnt), 64'(e.oc));
            cmp("err_ovf", 1, 64'(if3.err_ovf), 64'(e.ovf));
            cmp("err_unf", 1, 64'(if3.err_unf), 64'(e.unf));
         end
      end
   end

   initial begin
      reset = 1'b1;
      pol   = 1'b1;
      si    = 1'b0;
      ack   = 1'b0;
      di    = '0;
      #2;

      // Reset, then idle under both polarities.
      step(1, 1, 0, 64'h0, 0);
      step(0, 1, 0, 64'h0, 0);
      step(0, 0, 0, 64'h0, 0);

      // Fill even bank, overflow attempt, then drain through the switch side.
      for (int i = 0; i < 4; i++) step(0, 1, 1, 64'hA1 + 64'(i), 0);
      step(0, 1, 1, 64'hA5, 0);
      step(0, 1, 0, 64'h0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 64'h0, 1);
      step(0, 0, 0, 64'h0, 0);

      // Concurrent push to odd and pop of even in one cycle.
      step(1, 1, 0, 64'h0, 0);
      step(0, 1, 1, 64'hB0, 0);
      step(0, 0, 1, 64'h11, 1);
      step(0, 0, 0, 64'h0, 0);
      step(0, 1, 0, 64'h0, 0);

      // Pointer wrap across polarity toggles.
      step(1, 1, 0, 64'h0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 64'hC1 + 64'(i), 0);
      step(0, 0, 0, 64'h0, 1);
      step(0, 0, 0, 64'h0, 1);
      step(0, 1, 1, 64'hC4, 0);
      step(0, 1, 1, 64'hC5, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 64'h0, 1);
      step(0, 0, 0, 64'h0, 0);

      // Underflow is sticky until reset.
      step(1, 1, 0, 64'h0, 0);
      step(0, 1, 0, 64'h0, 1);
      step(0, 1, 1, 64'hD1, 0);
      step(0, 0, 0, 64'h0, 0);
      step(0, 1, 0, 64'h0, 0);

      // Reset with traffic pending on both banks.
      step(1, 1, 0, 64'h0, 0);
      step(0, 1, 1, 64'hE1, 0);
      step(0, 1, 1, 64'hE2, 0);
      step(0, 0, 1, 64'hE3, 0);
      step(1, 0, 1, 64'hE4, 1);
      step(0, 0, 0, 64'h0, 0);
      step(0, 1, 0, 64'h0, 0);

      // Random traffic with occasional flips and resets.
      for (int n = 0; n < 1500; n++) begin
         bit r = ($urandom_range(0, 199) == 0);
         bit p = ($urandom_range(0, 5) == 0) ? ~pol : pol;
         bit s = ($urandom_range(0, 9) < 6);
         bit a = ($urandom_range(0, 9) < 5);
         step(r, p, s, {$urandom, $urandom}, a);
      end

      step(0, pol, 0, 64'h0, 0);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/router_input_vc_buffer.md
# router_input_vc_buffer

Parametrised input stage for a cardinal ring router port. It holds two virtual-channel banks, even and odd, and each bank is a DEPTH-entry FIFO. The global `polarity` bit decides which bank accepts flits from the upstream link and which bank offers flits to the internal switch. This lets multiple flits queue per channel while upstream, downstream and polarity semantics stay as in the single-slot input controller. It adds occupancy reporting and sticky protocol-error flags.

## Interface
- DATA_W, 64, flit width in bits
- DEPTH, 4, entries per bank; any integer ≥ 1 (DEPTH=1 reproduces single-slot behaviour)
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override)
- clk  input  1  single clock, all state on posedge
- reset  input  1  synchronous, active-high
- polarity  input  1  1: external writes go to even bank, internal reads come from odd bank; 0: the reverse
- si  input  1  upstream send strobe, flit on di valid this cycle
- di  input  DATA_W  upstream flit
- ri  output  1  ready to upstream, meaning the write bank is not full
- req  output  1  request to switch, meaning the read bank is not empty
- dout  output  DATA_W  head flit of the read bank
- ack  input  1  switch grant, which pops the read-bank head this cycle
- even_cnt  output  CNT_W  even-bank occupancy
- odd_cnt  output  CNT_W  odd-bank occupancy
- err_ovf  output  1  sticky: si seen while ri=0
- err_unf  output  1  sticky: ack seen while req=0

## Operation
- Write bank is even when polarity=1 and odd when polarity=0. The read bank is always the other one.
- Because write and read banks always differ, a same-cycle push and pop never hit the same FIFO.
- Push: si=1 and ri=1 writes di at the write-bank tail. The tail pointer advances and wraps from DEPTH-1 to 0. That bank's count increments.
- si=1 with ri=0 is a dropped push: storage, pointers and counts are unchanged, and err_ovf is set.
- Pop: ack=1 and req=1 advances the read-bank head pointer (same wrap rule) and decrements that bank's count.
- ack=1 with req=0 does not change any state. It sets err_unf.
- The idle bank keeps its contents and count across polarity flips. Its flits become readable once polarity selects it for reading.
- Combinational outputs:
  - ri = (write-bank count != DEPTH)
  - req = (read-bank count != 0)
  - dout = storage[read-bank head]
- dout is don't-care-for-function when req=0, but it must still be driven from storage and never be X after reset.
- err_ovf and err_unf stay set until reset.

## Timing
- Reset values: even_cnt=0, odd_cnt=0, err_ovf=0, err_unf=0, all pointers 0, all storage 0. As a result ri=1, req=0 and dout=0 on the first cycle after reset, for either polarity.
- Reset has priority over si and ack in the same cycle. Reset mid-operation discards all queued flits.
- Push latency: a flit written at edge N drives dout/req from cycle N+1 if its bank is the read bank in N+1.
- ri, req and dout follow polarity combinationally in the same cycle, with no extra cycle on a flip.
- Full boundary: count==DEPTH gives ri=0. It returns to 1 the cycle after that bank is popped, which requires polarity to have selected it for reading.
- Empty boundary: count==0 gives req=0. A pop of the last entry drops req on the next cycle.
- Counts never exceed DEPTH and never underflow. A single-cycle polarity flip together with si and ack is legal; each acts on its bank per the current polarity.

## Structure
- Shared package `ring_noc_pkg`: polarity encoding constants (POL_WR_EVEN=1'b1, POL_WR_ODD=1'b0) and the default flit width FLIT_W=64 used by DATA_W.
- One sub-module, `router_vc_fifo`, with parameters DATA_W and DEPTH. Ports: push, din, pop, dout, count, full, empty, all on clk/reset. It is instantiated twice (even and odd).
- The top level holds the polarity steering muxes, the push/pop qualification, and the error flags.

## Test plan
- Reset then idle, DEPTH=4, polarity=1 -> ri=1, req=0, dout=0, both counts 0, both error flags 0.
- polarity=1, push 0xA1..0xA4 on 4 consecutive cycles -> even_cnt 1,2,3,4 and ri=0 after the 4th. A 5th si sets err_ovf with even_cnt staying 4. Then flip polarity to 0 -> req=1, dout=0xA1. Acks pop 0xA1..0xA4 in order and req drops after the last.
- Concurrent: polarity=0 with even bank holding 0xB0, si with 0x11 and ack in the same cycle -> odd_cnt=1, even_cnt=0, next cycle req=0.
- Wrap-around, DEPTH=3: push 5 flits and pop 5 across polarity toggles -> output order is preserved and counts return to 0 with pointers wrapped.
- ack with empty read bank -> err_unf=1 and counts unchanged. err_unf remains 1 until reset.
- Reset asserted while both banks are partially full (even_cnt=2, odd_cnt=1) with si=1 and ack=1 -> next cycle all counts 0, ri=1, req=0, flags 0.
